// File: rtl/pc_pkg.sv
// Shared widths, reset vector and address type for the program-counter register.
package pc_pkg;
  localparam int             PC_WIDTH        = 32;
  localparam logic [31:0]    PC_RESET_VECTOR = 32'h0000_0000;
  typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc_register.sv
// Program-counter state register: loads next_PC every rising clk edge, async reset.
// Optional PC_PREV_EN adds prev_PC, the PC held before the most recent load.
module pc_register
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] next_PC,
`ifdef PC_PREV_EN
  output logic [WIDTH-1:0] prev_PC,
`endif
  output logic [WIDTH-1:0] PC,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;

  // Stored unmodified: alignment is flagged, never forced.
  assign pc_d = next_PC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

`ifdef PC_PREV_EN
  logic [WIDTH-1:0] prev_q, prev_d;

  assign prev_d = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= RESET_VECTOR;
    else       prev_q <= prev_d;
  end

  assign prev_PC = prev_q;
`endif

  assign PC         = pc_q;
  assign misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: reset, loads, async reset, alignment flag, wrap.
module tb_pc_register;
  logic        clk;
  logic        reset;
  logic [31:0] next_PC;
  logic [31:0] PC;
  logic        misaligned;
`ifdef PC_PREV_EN
  logic [31:0] prev_PC;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pc_register #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .next_PC    (next_PC),
`ifdef PC_PREV_EN
    .prev_PC    (prev_PC),
`endif
    .PC         (PC),
    .misaligned (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    next_PC = 32'h0;
    #1;  chk("reset_pc", PC, 32'h0);
         chk("reset_mis", {31'b0, misaligned}, 32'h0);
    #5;  chk("reset_hold_edge", PC, 32'h0);
    #4;  reset = 1'b0; next_PC = 32'h0000_1004;
    #2;  chk("no_load_before_edge", PC, 32'h0);
    #4;  chk("seq_load", PC, 32'h0000_1004);
`ifdef PC_PREV_EN
         chk("prev_first", prev_PC, 32'h0);
`endif
    #4;  next_PC = 32'h0000_1010;
    #2;  chk("branch_hold", PC, 32'h0000_1004);
    #4;  chk("branch_load", PC, 32'h0000_1010);
`ifdef PC_PREV_EN
         chk("prev_branch", prev_PC, 32'h0000_1004);
`endif
    #2;  next_PC = 32'h0000_2000;
    #2;  reset = 1'b1;                 // between edges 25 and 35
    #1;  chk("async_reset", PC, 32'h0);
`ifdef PC_PREV_EN
         chk("prev_async_reset", prev_PC, 32'h0);
`endif
         next_PC = 32'hxxxx_xxxx;
    #5;  chk("x_blocked", PC, 32'h0);
         chk("x_blocked_mis", {31'b0, misaligned}, 32'h0);
    #4;  reset = 1'b0; next_PC = 32'h0000_1002;
    #6;  chk("mis_load", PC, 32'h0000_1002);
         chk("mis_flag", {31'b0, misaligned}, 32'h1);
    #4;  next_PC = 32'hFFFF_FFFC;
    #6;  chk("wrap_load", PC, 32'hFFFF_FFFC);
         chk("wrap_mis", {31'b0, misaligned}, 32'h0);
    #4;  next_PC = 32'h0000_1003;
    #6;  chk("mis3_load", PC, 32'h0000_1003);
         chk("mis3_flag", {31'b0, misaligned}, 32'h1);
`ifdef PC_PREV_EN
         chk("prev_wrap", prev_PC, 32'hFFFF_FFFC);
`endif
    #4;  next_PC = 32'h0000_2000;
    #5;  reset = 1'b1;                 // coincides with the edge at t=75
    #1;  chk("reset_wins_edge", PC, 32'h0);
    #4;  reset = 1'b0; next_PC = 32'h0000_0004;
    #6;  chk("post_reset_load", PC, 32'h0000_0004);
         chk("post_reset_mis", {31'b0, misaligned}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
